// File: rtl/pcs_transmit.sv
// 1000BASE-X PCS transmit: GMII to 8b/10b code groups (xmit=DATA only).
// Define TX_ERR_PROP_EN to send /V/ for data bytes flagged by TX_ER.
module pcs_transmit (
  input  logic       GTX_CLK,
  input  logic       mr_main_reset,
  input  logic [7:0] TXD,
  input  logic       TX_EN,
  input  logic       TX_ER,
  output logic       transmitting,
  output logic [9:0] tx_code_group
);

  typedef enum logic [2:0] {
    XMIT_DATA, START_OF_PACKET, TX_PACKET, END_OF_PACKET_NOEXT, EPD2_NOEXT, EPD3
  } oset_state_e;

  localparam logic [9:0] K28_5 = 10'b0011111010;
  localparam logic [9:0] K27_7 = 10'b1101101000;
  localparam logic [9:0] K29_7 = 10'b1011101000;
  localparam logic [9:0] K23_7 = 10'b1110101000;
  localparam logic [9:0] K30_7 = 10'b0111101000;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D5_6  = 8'hC5;

  function automatic logic [5:0] enc6(input logic [4:0] x);
    case (x)
      5'd0:  enc6 = 6'b100111;  5'd1:  enc6 = 6'b011101;
      5'd2:  enc6 = 6'b101101;  5'd3:  enc6 = 6'b110001;
      5'd4:  enc6 = 6'b110101;  5'd5:  enc6 = 6'b101001;
      5'd6:  enc6 = 6'b011001;  5'd7:  enc6 = 6'b111000;
      5'd8:  enc6 = 6'b111001;  5'd9:  enc6 = 6'b100101;
      5'd10: enc6 = 6'b010101;  5'd11: enc6 = 6'b110100;
      5'd12: enc6 = 6'b001101;  5'd13: enc6 = 6'b101100;
      5'd14: enc6 = 6'b011100;  5'd15: enc6 = 6'b010111;
      5'd16: enc6 = 6'b011011;  5'd17: enc6 = 6'b100011;
      5'd18: enc6 = 6'b010011;  5'd19: enc6 = 6'b110010;
      5'd20: enc6 = 6'b001011;  5'd21: enc6 = 6'b101010;
      5'd22: enc6 = 6'b011010;  5'd23: enc6 = 6'b111010;
      5'd24: enc6 = 6'b110011;  5'd25: enc6 = 6'b100110;
      5'd26: enc6 = 6'b010110;  5'd27: enc6 = 6'b110110;
      5'd28: enc6 = 6'b001110;  5'd29: enc6 = 6'b101110;
      5'd30: enc6 = 6'b011110;  default: enc6 = 6'b101011;
    endcase
  endfunction

  function automatic logic [3:0] enc4(input logic [2:0] y, input logic alt7);
    case (y)
      3'd0: enc4 = 4'b1011;  3'd1: enc4 = 4'b1001;
      3'd2: enc4 = 4'b0101;  3'd3: enc4 = 4'b1100;
      3'd4: enc4 = 4'b1101;  3'd5: enc4 = 4'b1010;
      3'd6: enc4 = 4'b0110;  default: enc4 = alt7 ? 4'b0111 : 4'b1110;
    endcase
  endfunction

  // Returns {rd_after, abcdeifghj}; tables hold the RD- form, rd=1 means positive.
  function automatic logic [10:0] encode_data(input logic [7:0] b, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic bal6, bal4, rd1, rd2, alt7;
    x = b[4:0];
    y = b[7:5];
    s6 = enc6(x);
    bal6 = ($countones(s6) == 3);
    if (rd_in && (!bal6 || x == 5'd7)) s6 = ~s6;
    rd1 = bal6 ? rd_in : ~rd_in;
    alt7 = rd1 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
               : (x == 5'd17 || x == 5'd18 || x == 5'd20);
    s4 = enc4(y, alt7);
    bal4 = ($countones(s4) == 2);
    if (rd1 && (!bal4 || y == 3'd3)) s4 = ~s4;
    rd2 = bal4 ? rd1 : ~rd1;
    encode_data = {rd2, s6, s4};
  endfunction

  oset_state_e state_q, state_d;
  logic        oset_q, oset_d;
  logic        even_q, even_d;
  logic        rd_q, rd_d;
  logic [9:0]  cg_q, cg_d;
  logic        transmitting_q, transmitting_d;
  logic [7:0]  txd_q;
  logic        kcode;
  logic [9:0]  kneg;
  logic [7:0]  dbyte;
  logic [10:0] enc;

`ifdef TX_ERR_PROP_EN
  logic er_q;
`else
  logic unused_tx_er;
  assign unused_tx_er = TX_ER;
`endif

  // Code-group generator: the ordered set is chosen by the state registered one edge earlier.
  always_comb begin
    even_d = ~even_q;
    oset_d = 1'b1;
    kcode  = 1'b1;
    kneg   = K23_7;
    dbyte  = txd_q;
    case (state_q)
      XMIT_DATA: begin
        if (oset_q) begin
          kneg   = K28_5;
          even_d = 1'b1;
          oset_d = 1'b0;
        end else begin
          kcode = 1'b0;
          dbyte = rd_q ? D16_2 : D5_6;
        end
      end
      START_OF_PACKET:     kneg = K27_7;
      END_OF_PACKET_NOEXT: kneg = K29_7;
      TX_PACKET: begin
`ifdef TX_ERR_PROP_EN
        if (er_q) kneg = K30_7;
        else      kcode = 1'b0;
`else
        kcode = 1'b0;
`endif
      end
      default: kneg = K23_7;
    endcase
    enc = encode_data(dbyte, rd_q);
    if (kcode) begin
      cg_d = rd_q ? ~kneg : kneg;
      rd_d = (kneg == K28_5) ? ~rd_q : rd_q;
    end else begin
      cg_d = enc[9:0];
      rd_d = enc[10];
    end
  end

  // Ordered-set machine moves only when the group produced on this edge closes a set.
  always_comb begin
    state_d = state_q;
    if (oset_d) begin
      case (state_q)
        XMIT_DATA:           if (TX_EN) state_d = START_OF_PACKET;
        START_OF_PACKET:     state_d = TX_PACKET;
        TX_PACKET:           if (!TX_EN) state_d = END_OF_PACKET_NOEXT;
        END_OF_PACKET_NOEXT: state_d = EPD2_NOEXT;
        EPD2_NOEXT:          state_d = even_d ? EPD3 : XMIT_DATA;
        default:             state_d = XMIT_DATA;
      endcase
    end
    transmitting_d = (state_d == START_OF_PACKET) || (state_d == TX_PACKET);
  end

  always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q        <= XMIT_DATA;
      oset_q         <= 1'b1;
      even_q         <= 1'b0;
      rd_q           <= 1'b0;
      cg_q           <= 10'b0;
      transmitting_q <= 1'b0;
      txd_q          <= 8'h00;
`ifdef TX_ERR_PROP_EN
      er_q           <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      oset_q         <= oset_d;
      even_q         <= even_d;
      rd_q           <= rd_d;
      cg_q           <= cg_d;
      transmitting_q <= transmitting_d;
      txd_q          <= TXD;
`ifdef TX_ERR_PROP_EN
      er_q           <= TX_ER;
`endif
    end
  end

  assign transmitting  = transmitting_q;
  assign tx_code_group = cg_q;

endmodule

// File: tb/tb_pcs_transmit.sv
// Directed-vector bench for pcs_transmit; honours TX_ERR_PROP_EN when defined.
module tb_pcs_transmit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] txd = 8'h00;
  logic       tx_en = 1'b0;
  logic       tx_er = 1'b0;
  logic       transmitting;
  logic [9:0] tx_code_group;

  int checks = 0;
  int failures = 0;

  localparam logic [9:0] K28N = 10'b0011111010;
  localparam logic [9:0] K28P = 10'b1100000101;
  localparam logic [9:0] I2   = 10'b1001000101;
  localparam logic [9:0] I1   = 10'b1010010110;
  localparam logic [9:0] SN   = 10'b1101101000;
  localparam logic [9:0] TN   = 10'b1011101000;
  localparam logic [9:0] TP   = 10'b0100010111;
  localparam logic [9:0] RN   = 10'b1110101000;
  localparam logic [9:0] RP   = 10'b0001010111;
`ifdef TX_ERR_PROP_EN
  localparam logic [9:0] ERRCG = 10'b0111101000;
`else
  localparam logic [9:0] ERRCG = 10'b1011010100;
`endif

  pcs_transmit dut (
    .GTX_CLK       (clk),
    .mr_main_reset (rst_n),
    .TXD           (txd),
    .TX_EN         (tx_en),
    .TX_ER         (tx_er),
    .transmitting  (transmitting),
    .tx_code_group (tx_code_group)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       er;
    logic [7:0] d;
    logic       tr;
    logic [9:0] cg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic er, input logic [7:0] d,
                              input logic tr, input logic [9:0] cg);
    vec_t v;
    v.en = en; v.er = er; v.d = d; v.tr = tr; v.cg = cg;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  initial begin
    // Idle stream straight out of reset
    for (int i = 1; i <= 10; i++) add(1'b0, 1'b0, 8'h00, 1'b0, (i % 2 == 1) ? K28N : I2);
    add(0, 0, 8'h00, 0, K28N);
    // Aligned start, 4 data bytes, even length -> two /R/
    add(1, 0, 8'h55, 1, I2);
    add(1, 0, 8'h01, 1, SN);
    add(1, 0, 8'h02, 1, 10'b0111010100);
    add(1, 0, 8'h03, 1, 10'b1011010100);
    add(1, 0, 8'h42, 1, 10'b1100011011);
    add(0, 0, 8'h00, 0, 10'b0100100101);
    add(0, 0, 8'h00, 0, TN);
    add(0, 0, 8'h00, 0, RN);
    add(0, 0, 8'h00, 0, RN);
    add(0, 0, 8'h00, 0, K28N);
    add(0, 0, 8'h00, 0, I2);
    // Start requested on the K28.5 edge: byte AA dropped, one-byte packet -> one /R/
    add(1, 1, 8'hAA, 0, K28N);
    add(1, 0, 8'h55, 1, I2);
    add(1, 0, 8'h07, 1, SN);
    add(0, 0, 8'h00, 0, 10'b1110001011);
    add(0, 0, 8'h00, 0, TP);
    add(0, 0, 8'h00, 0, RP);
    add(0, 0, 8'h00, 0, K28P);
    add(0, 0, 8'h00, 0, I1);
    add(0, 0, 8'h00, 0, K28N);
    add(0, 0, 8'h00, 0, I2);
    add(0, 0, 8'h00, 0, K28N);
    // Packet with TX_ER on the second data byte
    add(1, 0, 8'h55, 1, I2);
    add(1, 0, 8'h01, 1, SN);
    add(1, 1, 8'h02, 1, 10'b0111010100);
    add(1, 0, 8'h03, 1, ERRCG);
    add(0, 0, 8'h00, 0, 10'b1100011011);
    add(0, 0, 8'h00, 0, TP);
    add(0, 0, 8'h00, 0, RP);
    add(0, 0, 8'h00, 0, K28P);
    add(0, 0, 8'h00, 0, I1);
    // Packet interrupted by reset after its first data byte
    add(0, 0, 8'h00, 0, K28N);
    add(1, 0, 8'h55, 1, I2);
    add(1, 0, 8'h01, 1, SN);
    add(1, 0, 8'h02, 1, 10'b0111010100);

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_cg", tx_code_group, 10'b0);
    check("reset_tr", {9'b0, transmitting}, 10'b0);
    $display("reset: cg=%b tr=%b", tx_code_group, transmitting);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      tx_en = vecs[i].en;
      tx_er = vecs[i].er;
      txd   = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("row%0d_cg", i + 1), tx_code_group, vecs[i].cg);
      check($sformatf("row%0d_tr", i + 1), {9'b0, transmitting}, {9'b0, vecs[i].tr});
      $display("row %0d en=%b er=%b txd=%h -> cg=%b tr=%b", i + 1, vecs[i].en, vecs[i].er,
               vecs[i].d, tx_code_group, transmitting);
    end

    // Asynchronous reset mid-packet clears outputs without a clock edge
    #1 rst_n = 1'b0;
    #1;
    check("midreset_cg", tx_code_group, 10'b0);
    check("midreset_tr", {9'b0, transmitting}, 10'b0);
    $display("mid-packet reset: cg=%b tr=%b", tx_code_group, transmitting);
    @(negedge clk);
    tx_en = 1'b0;
    tx_er = 1'b0;
    txd   = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_k28", tx_code_group, K28N);
    check("restart_tr", {9'b0, transmitting}, 10'b0);
    $display("restart 1: cg=%b tr=%b", tx_code_group, transmitting);
    @(posedge clk);
    #1;
    check("restart_i2", tx_code_group, I2);
    $display("restart 2: cg=%b tr=%b", tx_code_group, transmitting);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
